sysid_checker: RTL and testbench
================================

SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'h0000_0000, is the expected system ID word read at address 0.
REQ-002 Parameter EXPECTED_TS, default 32'd1445573127, is the expected build timestamp read at address 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, is the maximum number of consecutive waitrequest-high cycles tolerated per read.
REQ-004 Port clock, input, 1: the single clock; all logic is rising-edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: a one-cycle pulse that starts a check sequence.
REQ-007 Port avm_address, output, 1: word address presented to the sysid slave.
REQ-008 Port avm_read, output, 1: Avalon-MM read strobe.
REQ-009 Port avm_readdata, input, 32: slave read data, valid in the cycle avm_read=1 and avm_waitrequest=0.
REQ-010 Port avm_waitrequest, input, 1: slave stall; tie to 0 for a zero-wait slave.
REQ-011 Port busy, output, 1: a sequence is in progress.
REQ-012 Port done, output, 1: a one-cycle pulse when a sequence ends, whether by pass, fail or timeout.
REQ-013 Port id_ok / ts_ok, output, 1 each: sticky compare results of the last sequence.
REQ-014 Port timeout, output, 1: sticky flag; the last sequence aborted on a stall.
REQ-015 Port id_value / ts_value, output, 32 each: captured read words.

Function
REQ-016 The FSM SHALL have states IDLE, RD_ID, RD_TS, CMP and FIN.
REQ-017 IDLE->RD_ID SHALL occur on start=1; start SHALL be ignored in every other state.
REQ-018 On entering RD_ID, id_ok, ts_ok and timeout SHALL clear.
REQ-019 In RD_ID, outputs SHALL be avm_read=1 and avm_address=0; when avm_waitrequest=0, id_value<=avm_readdata and the FSM moves to RD_TS.
REQ-020 In RD_TS, outputs SHALL be avm_read=1 and avm_address=1; when avm_waitrequest=0, ts_value<=avm_readdata and the FSM moves to CMP.
REQ-021 avm_read and avm_address SHALL be registered outputs and SHALL hold stable while avm_waitrequest=1.
REQ-022 A wait counter SHALL clear on each read accept and increment on each stalled cycle.
REQ-023 When the wait counter reaches TIMEOUT_CYCLES, the FSM SHALL drop avm_read, set timeout=1, leave the *_value outputs unchanged for reads not completed, and go to FIN.
REQ-024 CMP SHALL last one cycle: id_ok<=(id_value==EXPECTED_ID) and ts_ok<=(ts_value==EXPECTED_TS); then FIN.
REQ-025 FIN SHALL assert done for exactly one cycle and then return to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 With zero-wait slave data, the time from start to done SHALL be exactly 4 cycles: start at cycle 0, done at cycle 4.
REQ-028 start arriving in the same cycle as FIN SHALL be ignored; a new sequence requires start while in IDLE.
REQ-029 The wait counter SHALL be wide enough to count to TIMEOUT_CYCLES without wrap.

Reset
REQ-030 While reset=1, the FSM SHALL go to IDLE and all of the following SHALL be 0: avm_read, avm_address, busy, done, id_ok, ts_ok, timeout, id_value, ts_value and the counters.
REQ-031 Reset mid-sequence SHALL abort immediately with no done pulse, and reset SHALL take priority over start.

Configuration
REQ-032 With macro SYSID_CHECKER_PERIODIC_EN defined, a free-running counter SHALL auto-issue an internal start every 2^20 cycles while in IDLE, OR-ed with the start port.
REQ-033 With SYSID_CHECKER_PERIODIC_EN undefined, the periodic counter SHALL be absent and sequences SHALL start only from the start port.

Structure
REQ-034 Package sysid_pkg SHALL hold the FSM state enum, the address constants SYSID_ADDR_ID=0 and SYSID_ADDR_TS=1, and the period constant.
REQ-035 There SHALL be no sub-modules except one: a sub-module sysid_wait_timer holding the wait counter and timeout compare.

Verification
REQ-036 Zero-wait slave returning 0 and 1445573127, start pulse -> done at cycle 4, id_ok=1, ts_ok=1, timeout=0.
REQ-037 Slave returning 32'h1 at address 0 -> id_ok=0, ts_ok=1, id_value=32'h1.
REQ-038 Waitrequest high for 3 cycles on each read -> done at cycle 10, both ok=1, avm_address stable during stalls.
REQ-039 Waitrequest stuck high on RD_TS -> timeout=1, done at cycle 2+16+1, ts_ok=0, avm_read=0 after abort.
REQ-040 Reset asserted in RD_TS -> next cycle all outputs 0, no done pulse; a subsequent start completes normally.
REQ-041 start re-pulsed while busy -> ignored, and exactly one done pulse is produced.

Source files
------------

// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID checker: FSM states, slave
// word addresses and the auto-check period.
package sysid_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    CMP   = 3'd3,
    FIN   = 3'd4
  } sysid_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int          SYSID_PERIOD_LOG2 = 20;
  localparam int unsigned SYSID_PERIOD      = 32'd1 << SYSID_PERIOD_LOG2;

endpackage

// File: rtl/sysid_wait_timer.sv
// Stall counter for one Avalon read: counts consecutive waitrequest cycles and
// flags when the tolerated number of stalls has been used up.
module sysid_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] count;

  assign expired = (count == LIMIT);

  // Saturates at the limit so the counter can never wrap back to zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (stall && !expired) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// Reads the system ID and build timestamp words from a sysid slave and compares
// them with the expected values. Define SYSID_CHECKER_PERIODIC_EN to also
// re-run the check automatically every 2^20 cycles while idle.
//
// state | meaning
// IDLE  | waiting for start
// RD_ID | reading ID word (address 0)
// RD_TS | reading timestamp word (address 1)
// CMP   | comparing captured words against expected
// FIN   | done pulse, then back to IDLE
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1445573127,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  sysid_state_t state;
  logic         start_any;
  logic         timer_clear;
  logic         timer_stall;
  logic         expired;

`ifdef SYSID_CHECKER_PERIODIC_EN
  logic [SYSID_PERIOD_LOG2-1:0] period_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + SYSID_PERIOD_LOG2'(1);
    end
  end

  assign start_any = start || ((period_cnt == '1) && (state == IDLE));
`else
  assign start_any = start;
`endif

  // avm_read is high exactly in RD_ID/RD_TS, so it doubles as "read pending".
  assign timer_stall = avm_read && avm_waitrequest;
  assign timer_clear = !avm_read || !avm_waitrequest || expired;

  sysid_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .stall   (timer_stall),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      avm_read    <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_any) begin
            state       <= RD_ID;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_ID;
            busy        <= 1'b1;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        RD_ID, RD_TS: begin
          // An exhausted stall budget wins over a late accept.
          if (expired) begin
            state       <= FIN;
            avm_read    <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            timeout     <= 1'b1;
            done        <= 1'b1;
          end else if (!avm_waitrequest) begin
            if (state == RD_ID) begin
              id_value    <= avm_readdata;
              avm_address <= SYSID_ADDR_TS;
              state       <= RD_TS;
            end else begin
              ts_value    <= avm_readdata;
              avm_read    <= 1'b0;
              avm_address <= SYSID_ADDR_ID;
              state       <= CMP;
            end
          end
        end
        CMP: begin
          id_ok <= (id_value == EXPECTED_ID);
          ts_ok <= (ts_value == EXPECTED_TS);
          done  <= 1'b1;
          state <= FIN;
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          avm_read    <= 1'b0;
          avm_address <= SYSID_ADDR_ID;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: a behavioural sysid slave, expected results
// queued at each start and checked when done pulses.
module tb_sysid_checker;

  localparam logic [31:0] TS_GOOD = 32'd1445573127;

  typedef struct {
    int          lat;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  logic [31:0] id_word;
  logic [31:0] ts_word;
  int          stall_cfg  = 0;
  int          stall_left = 0;
  bit          stuck_ts   = 1'b0;

  int   cyc       = 0;
  int   start_cyc = 0;
  int   done_cnt  = 0;
  int   passed    = 0;
  int   total     = 0;
  exp_t sb_q[$];

  sysid_checker dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .timeout         (timeout),
    .id_value        (id_value),
    .ts_value        (ts_value)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Slave: stalls stall_cfg cycles at the start of every read; optionally never
  // answers the timestamp address.
  assign avm_readdata    = avm_address ? ts_word : id_word;
  assign avm_waitrequest = avm_read && ((stall_left != 0) || (stuck_ts && avm_address));

  always @(posedge clock) begin
    if (!avm_read || stall_left == 0) stall_left <= stall_cfg;
    else                               stall_left <= stall_left - 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  always @(negedge clock) begin
    if (done === 1'b1) begin
      exp_t e;
      done_cnt++;
      chk("done_expected", 32'(sb_q.size() != 0), 32'(1));
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("latency",  32'(cyc - start_cyc), 32'(e.lat));
        chk("id_ok",    32'(id_ok),   32'(e.id_ok));
        chk("ts_ok",    32'(ts_ok),   32'(e.ts_ok));
        chk("timeout",  32'(timeout), 32'(e.timeout));
        chk("id_value", id_value, e.id_value);
        chk("ts_value", ts_value, e.ts_value);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic do_start(input exp_t e);
    start     = 1'b1;
    start_cyc = cyc;
    sb_q.push_back(e);
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max, input bit check_stable);
    int   n = 0;
    logic prev_rd, prev_wr, prev_addr;
    while (sb_q.size() != 0 && n < max) begin
      prev_rd   = avm_read;
      prev_wr   = avm_waitrequest;
      prev_addr = avm_address;
      tick(1);
      n++;
      if (check_stable && prev_rd && prev_wr) begin
        chk("stall_addr_hold", 32'(avm_address), 32'(prev_addr));
        chk("stall_read_hold", 32'(avm_read), 32'(1));
      end
    end
    chk("seq_complete", 32'(sb_q.size()), 32'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read"},     32'(avm_read),    32'(0));
    chk({tag, "_addr"},     32'(avm_address), 32'(0));
    chk({tag, "_busy"},     32'(busy),        32'(0));
    chk({tag, "_done"},     32'(done),        32'(0));
    chk({tag, "_id_ok"},    32'(id_ok),       32'(0));
    chk({tag, "_ts_ok"},    32'(ts_ok),       32'(0));
    chk({tag, "_timeout"},  32'(timeout),     32'(0));
    chk({tag, "_id_value"}, id_value,         32'(0));
    chk({tag, "_ts_value"}, ts_value,         32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_before;
    reset   = 1'b1;
    start   = 1'b0;
    id_word = 32'h0;
    ts_word = TS_GOOD;
    tick(3);
    chk_all_zero("reset");
    reset = 1'b0;
    tick(2);

    // Zero-wait, matching words.
    do_start('{4, 1'b1, 1'b1, 1'b0, 32'h0, TS_GOOD});
    chk("rd_id_busy", 32'(busy),        32'(1));
    chk("rd_id_read", 32'(avm_read),    32'(1));
    chk("rd_id_addr", 32'(avm_address), 32'(0));
    tick(1);
    chk("rd_ts_addr", 32'(avm_address), 32'(1));
    wait_idle(30, 1'b0);
    tick(1);
    chk("idle_busy", 32'(busy), 32'(0));

    // Wrong ID word.
    id_word = 32'h1;
    do_start('{4, 1'b0, 1'b1, 1'b0, 32'h1, TS_GOOD});
    wait_idle(30, 1'b0);
    tick(2);

    // Three stall cycles on each read.
    id_word   = 32'h0;
    stall_cfg = 3;
    tick(2);
    do_start('{10, 1'b1, 1'b1, 1'b0, 32'h0, TS_GOOD});
    wait_idle(40, 1'b1);
    tick(2);

    // Timestamp read never accepted: abort, ts_value keeps its old contents.
    stall_cfg = 0;
    stuck_ts  = 1'b1;
    ts_word   = 32'hDEAD_BEEF;
    tick(2);
    do_start('{19, 1'b0, 1'b0, 1'b1, 32'h0, TS_GOOD});
    wait_idle(60, 1'b0);
    chk("abort_read_low", 32'(avm_read), 32'(0));
    tick(1);
    chk("abort_read_after", 32'(avm_read), 32'(0));
    chk("abort_busy_after", 32'(busy),     32'(0));
    stuck_ts = 1'b0;
    ts_word  = TS_GOOD;
    tick(2);

    // Reset in RD_TS: immediate abort, no done, then a clean sequence.
    done_before = done_cnt;
    stall_cfg   = 2;
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    chk("pre_reset_addr", 32'(avm_address), 32'(1));
    reset = 1'b1;
    start = 1'b1;
    tick(1);
    chk_all_zero("mid_reset");
    start = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(4);
    chk("no_done_on_reset", 32'(done_cnt), 32'(done_before));
    stall_cfg = 0;
    tick(2);
    do_start('{4, 1'b1, 1'b1, 1'b0, 32'h0, TS_GOOD});
    wait_idle(30, 1'b0);
    tick(2);

    // start re-pulsed while busy and again during FIN.
    done_before = done_cnt;
    do_start('{4, 1'b1, 1'b1, 1'b0, 32'h0, TS_GOOD});
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    chk("fin_done", 32'(done), 32'(1));
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    chk("fin_start_ignored", 32'(busy), 32'(0));
    tick(6);
    chk("single_done", 32'(done_cnt), 32'(done_before + 1));
    chk("sb_drained",  32'(sb_q.size()), 32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
